bp_two_level_local_predictor: RTL and testbench



---
 rtl/bp_tlp_pkg.sv | 26 ++
 rtl/bp_tlp_init_sweep.sv | 43 ++++
 rtl/bp_two_level_local_predictor.sv | 109 ++++++++++
 tb/tb_bp_two_level_local_predictor.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/bp_tlp_pkg.sv
// Shared types and helper functions for the two-level local branch predictor.
package bp_tlp_pkg;

  typedef enum logic {e_init, e_ready} tlp_state_e;

  // Widest counter the helpers handle; ctr_width_p must not exceed this.
  localparam int CTR_MAX_W = 8;
  typedef logic [CTR_MAX_W-1:0] ctr_t;

  function automatic int sweep_depth(input int bht_idx_w, input int pht_idx_w);
    return (bht_idx_w > pht_idx_w) ? (1 << bht_idx_w) : (1 << pht_idx_w);
  endfunction

  function automatic ctr_t weak_not_taken(input int ctr_w);
    return (ctr_w <= 1) ? '0 : ctr_t'((1 << (ctr_w - 1)) - 1);
  endfunction

  function automatic ctr_t sat_ctr(input ctr_t ctr, input logic taken, input int ctr_w);
    ctr_t max_v;
    max_v = ctr_t'((1 << ctr_w) - 1);
    if (taken)
      return (ctr == max_v) ? ctr : ctr + ctr_t'(1);
    return (ctr == '0) ? ctr : ctr - ctr_t'(1);
  endfunction

endpackage

// File: rtl/bp_tlp_init_sweep.sv
// Post-reset table initialisation sequencer: walks init_addr over every table
// entry once, then raises ready until the next reset.
module bp_tlp_init_sweep
  import bp_tlp_pkg::*;
#(
  parameter int sweep_depth_p = 64,
  parameter int cnt_width_p   = 6
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  output logic                   init_v,
  output logic [cnt_width_p-1:0] init_addr,
  output logic                   ready
);

  localparam logic [cnt_width_p-1:0] LAST = cnt_width_p'(sweep_depth_p - 1);

  tlp_state_e state;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= e_init;
      init_addr <= '0;
      init_v    <= 1'b1;
      ready     <= 1'b0;
    end else begin
      case (state)
        e_init: begin
          // Counter parks on the last entry rather than wrapping.
          if (init_addr == LAST) begin
            state  <= e_ready;
            init_v <= 1'b0;
            ready  <= 1'b1;
          end else begin
            init_addr <= init_addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bp_two_level_local_predictor.sv
// Two-level local-history predictor: per-PC history table feeding a table of
// saturating counters. Registered lookup, separate resolved-branch update.
module bp_two_level_local_predictor
  import bp_tlp_pkg::*;
#(
  parameter int vaddr_width_p   = 32,
  parameter int pc_lsb_p        = 2,
  parameter int bht_idx_width_p = 6,
  parameter int hist_width_p    = 4,
  parameter int pht_pc_bits_p   = 2,
  parameter int ctr_width_p     = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     lookup_v_i,
  input  logic [vaddr_width_p-1:0] lookup_pc_i,
  output logic                     lookup_ready_o,
  output logic                     pred_v_o,
  output logic                     pred_taken_o,
  output logic [hist_width_p-1:0]  pred_hist_o,
  input  logic                     update_v_i,
  input  logic [vaddr_width_p-1:0] update_pc_i,
  input  logic [hist_width_p-1:0]  update_hist_i,
  input  logic                     update_taken_i
);

  localparam int BHT_DEPTH   = 1 << bht_idx_width_p;
  localparam int PHT_IDX_W   = pht_pc_bits_p + hist_width_p;
  localparam int PHT_DEPTH   = 1 << PHT_IDX_W;
  localparam int SWEEP_DEPTH = sweep_depth(bht_idx_width_p, PHT_IDX_W);
  localparam int CNT_W       = (SWEEP_DEPTH > 1) ? $clog2(SWEEP_DEPTH) : 1;
  localparam logic [ctr_width_p-1:0] WEAK_NT = ctr_width_p'(weak_not_taken(ctr_width_p));

  logic [hist_width_p-1:0] bht_mem [BHT_DEPTH];
  logic [ctr_width_p-1:0]  pht_mem [PHT_DEPTH];

  logic             init_v, ready;
  logic [CNT_W-1:0] init_addr;

  bp_tlp_init_sweep #(
    .sweep_depth_p(SWEEP_DEPTH),
    .cnt_width_p  (CNT_W)
  ) u_init_sweep (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .init_v   (init_v),
    .init_addr(init_addr),
    .ready    (ready)
  );

  assign lookup_ready_o = ready;

  logic [bht_idx_width_p-1:0] lk_bht_idx, up_bht_idx;
  logic [hist_width_p-1:0]    lk_hist;
  logic [PHT_IDX_W-1:0]       lk_pht_idx, up_pht_idx;

  assign lk_bht_idx = lookup_pc_i[pc_lsb_p +: bht_idx_width_p];
  assign up_bht_idx = update_pc_i[pc_lsb_p +: bht_idx_width_p];
  assign lk_hist    = bht_mem[lk_bht_idx];

  if (pht_pc_bits_p == 0) begin : g_pag
    assign lk_pht_idx = lk_hist;
    assign up_pht_idx = update_hist_i;
  end else begin : g_pap
    assign lk_pht_idx = {lookup_pc_i[pc_lsb_p +: pht_pc_bits_p], lk_hist};
    assign up_pht_idx = {update_pc_i[pc_lsb_p +: pht_pc_bits_p], update_hist_i};
  end

  logic [ctr_width_p-1:0] up_ctr_next;
  assign up_ctr_next = ctr_width_p'(sat_ctr(ctr_t'(pht_mem[up_pht_idx]), update_taken_i, ctr_width_p));

  // Tables carry no reset so they stay RAM-inferable; the sweep clears them.
  always_ff @(posedge clk_i) begin
    if (init_v) begin
      if (32'(init_addr) < BHT_DEPTH)
        bht_mem[bht_idx_width_p'(init_addr)] <= '0;
    end else if (ready && update_v_i) begin
      bht_mem[up_bht_idx] <= (bht_mem[up_bht_idx] << 1) | hist_width_p'(update_taken_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (init_v) begin
      if (32'(init_addr) < PHT_DEPTH)
        pht_mem[PHT_IDX_W'(init_addr)] <= WEAK_NT;
    end else if (ready && update_v_i) begin
      pht_mem[up_pht_idx] <= up_ctr_next;
    end
  end

  // Lookup samples the tables before this edge's update lands: read-old, no bypass.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pred_v_o     <= 1'b0;
      pred_taken_o <= 1'b0;
      pred_hist_o  <= '0;
    end else begin
      pred_v_o <= ready & lookup_v_i;
      if (ready && lookup_v_i) begin
        pred_hist_o  <= lk_hist;
        pred_taken_o <= pht_mem[lk_pht_idx][ctr_width_p-1];
      end
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc_i, update_pc_i};

endmodule

// File: tb/tb_bp_two_level_local_predictor.sv
// Directed-vector bench for the two-level local predictor at default parameters.
module tb_bp_two_level_local_predictor;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        lookup_v_i;
  logic [31:0] lookup_pc_i;
  logic        lookup_ready_o;
  logic        pred_v_o;
  logic        pred_taken_o;
  logic [3:0]  pred_hist_o;
  logic        update_v_i;
  logic [31:0] update_pc_i;
  logic [3:0]  update_hist_i;
  logic        update_taken_i;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  bp_two_level_local_predictor dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .lookup_v_i    (lookup_v_i),
    .lookup_pc_i   (lookup_pc_i),
    .lookup_ready_o(lookup_ready_o),
    .pred_v_o      (pred_v_o),
    .pred_taken_o  (pred_taken_o),
    .pred_hist_o   (pred_hist_o),
    .update_v_i    (update_v_i),
    .update_pc_i   (update_pc_i),
    .update_hist_i (update_hist_i),
    .update_taken_i(update_taken_i)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (lookup_ready_o !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 32'(n), 32'd64);
  endtask

  task automatic lookup(input logic [31:0] pc, output logic taken, output logic [3:0] hist);
    lookup_v_i  = 1'b1;
    lookup_pc_i = pc;
    tick();
    lookup_v_i = 1'b0;
    chk("lk_pred_v", 32'(pred_v_o), 32'd1);
    taken = pred_taken_o;
    hist  = pred_hist_o;
  endtask

  task automatic update(input logic [31:0] pc, input logic [3:0] hist, input logic taken);
    update_v_i     = 1'b1;
    update_pc_i    = pc;
    update_hist_i  = hist;
    update_taken_i = taken;
    tick();
    update_v_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       t;
    logic [3:0] h;
    logic       o;
    int         miss;

    reset_i = 1'b1; lookup_v_i = 1'b0; lookup_pc_i = '0;
    update_v_i = 1'b0; update_pc_i = '0; update_hist_i = '0; update_taken_i = 1'b0;

    // Reset state and the initialisation sweep length
    repeat (3) tick();
    chk("rst_pred_v", 32'(pred_v_o), 32'd0);
    chk("rst_ready", 32'(lookup_ready_o), 32'd0);
    chk("rst_hist", 32'(pred_hist_o), 32'd0);
    chk("rst_taken", 32'(pred_taken_o), 32'd0);
    reset_i = 1'b0;
    wait_ready("init_len");

    lookup(32'h100, t, h);
    chk("init_taken", 32'(t), 32'd0);
    chk("init_hist", 32'(h), 32'd0);
    tick();
    chk("pred_v_pulse", 32'(pred_v_o), 32'd0);

    // History shift: BHT[16] 0000->0001->0011, PHT[0] 01->10->11
    update(32'h40, 4'b0000, 1'b1);
    update(32'h40, 4'b0000, 1'b1);
    lookup(32'h40, t, h);
    chk("shift_hist", 32'(h), 32'h3);
    chk("shift_taken", 32'(t), 32'd0);
    lookup(32'h100, t, h);
    chk("pht0_sat_taken", 32'(t), 32'd1);

    // Saturation: PHT[10] 01 -> 11 (held) -> 10; then shift BHT[0] to 1010
    repeat (5) update(32'h0, 4'b1010, 1'b1);
    update(32'h0, 4'b1010, 1'b0);
    update(32'h0, 4'b1111, 1'b1);
    update(32'h0, 4'b1111, 1'b0);
    update(32'h0, 4'b1111, 1'b1);
    update(32'h0, 4'b1111, 1'b0);
    lookup(32'h0, t, h);
    chk("sat_hist", 32'(h), 32'hA);
    chk("sat_taken", 32'(t), 32'd1);

    // Pattern learning: TTTN on pc 0x80, feeding back the returned history
    miss = 0;
    for (int p = 0; p < 8; p++) begin
      for (int k = 0; k < 4; k++) begin
        o = (k != 3);
        lookup(32'h80, t, h);
        if (p >= 6 && t !== o) miss++;
        update(32'h80, h, o);
      end
    end
    chk("pattern_miss", 32'(miss), 32'd0);

    // Read-old collision: BHT[16]=0011, PHT[3]=10 before this edge
    lookup_v_i = 1'b1; lookup_pc_i = 32'h40;
    update_v_i = 1'b1; update_pc_i = 32'h40; update_hist_i = 4'b0011; update_taken_i = 1'b0;
    tick();
    lookup_v_i = 1'b0; update_v_i = 1'b0;
    chk("coll_v", 32'(pred_v_o), 32'd1);
    chk("coll_hist_old", 32'(pred_hist_o), 32'h3);
    chk("coll_taken_old", 32'(pred_taken_o), 32'd1);
    lookup(32'h40, t, h);
    chk("coll_hist_new", 32'(h), 32'h6);
    chk("coll_taken_new", 32'(t), 32'd0);

    // Reset at sweep cycle 20, with lookups offered during the sweep
    reset_i = 1'b1;
    repeat (3) tick();
    reset_i = 1'b0;
    lookup_v_i = 1'b1; lookup_pc_i = 32'h100;
    repeat (20) tick();
    chk("sweep_no_pred", 32'(pred_v_o), 32'd0);
    chk("sweep_not_ready", 32'(lookup_ready_o), 32'd0);
    #2 reset_i = 1'b1;
    #1;
    chk("midsweep_rst_ready", 32'(lookup_ready_o), 32'd0);
    lookup_v_i = 1'b0;
    tick();
    reset_i = 1'b0;
    wait_ready("init_len_restart");

    // Async reset during a pending prediction
    lookup_v_i = 1'b1; lookup_pc_i = 32'h100;
    tick();
    lookup_v_i = 1'b0;
    chk("pend_pred_v", 32'(pred_v_o), 32'd1);
    chk("pend_ready", 32'(lookup_ready_o), 32'd1);
    #2 reset_i = 1'b1;
    #1;
    chk("async_pred_v", 32'(pred_v_o), 32'd0);
    chk("async_ready", 32'(lookup_ready_o), 32'd0);
    tick();
    reset_i = 1'b0;
    wait_ready("init_len_after_async");
    lookup(32'h100, t, h);
    chk("retrain_taken", 32'(t), 32'd0);
    chk("retrain_hist", 32'(h), 32'd0);
    lookup(32'h80, t, h);
    chk("retrain80_hist", 32'(h), 32'd0);
    chk("retrain80_taken", 32'(t), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
